// File: rtl/random_pulse_scheduler_if.sv
// Control/status bundle for random_pulse_scheduler: burst requests and
// configuration in, pulse and status out.
interface random_pulse_scheduler_if;
  logic        start;
  logic        stop;
  logic [3:0]  burst_len;
  logic [7:0]  min_gap;
  logic [7:0]  gap_mask;
  logic [3:0]  pulse_width;
  logic        seed_load;
  logic [15:0] seed;
  logic        pulse;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_count;

  modport master (
    output start, stop, burst_len, min_gap, gap_mask, pulse_width, seed_load, seed,
    input  pulse, busy, done, pulse_count
  );

  modport slave (
    input  start, stop, burst_len, min_gap, gap_mask, pulse_width, seed_load, seed,
    output pulse, busy, done, pulse_count
  );
endinterface

// File: rtl/random_pulse_scheduler.sv
// Burst pulse generator with LFSR-randomised inter-pulse gaps.
// Optional pulse counter enabled by defining RPS_STATS_EN.
module random_pulse_scheduler #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  random_pulse_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_PULSE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]  width_cnt_q, width_cnt_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        pulse_q, pulse_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] lfsr_base;
  logic [15:0] lfsr_next;
  logic [8:0]  gap_val;
  logic [3:0]  width_load;
  logic [3:0]  burst_inc;
  logic        pulse_enter;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [15:0] seed_sel(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_SEED : s;
  endfunction

  always_comb begin
    // A seed load coinciding with start must feed the very first advance.
    lfsr_base  = (state_q == S_IDLE && bus.seed_load) ? seed_sel(bus.seed) : lfsr_q;
    lfsr_next  = lfsr_step(lfsr_base);
    gap_val    = {1'b0, bus.min_gap} + {1'b0, lfsr_next[7:0] & bus.gap_mask};
    width_load = (bus.pulse_width == 4'd0) ? 4'd0 : bus.pulse_width - 4'd1;
    burst_inc  = burst_cnt_q + 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    gap_cnt_d   = gap_cnt_q;
    width_cnt_d = width_cnt_q;
    burst_cnt_d = burst_cnt_q;
    pulse_enter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.seed_load) lfsr_d = lfsr_base;
        if (bus.start) begin
          state_d     = S_GAP;
          lfsr_d      = lfsr_next;
          gap_cnt_d   = gap_val;
          burst_cnt_d = 4'd0;
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (gap_cnt_q == 9'd0) begin
          state_d     = S_PULSE;
          width_cnt_d = width_load;
          pulse_enter = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 9'd1;
        end
      end
      S_PULSE: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (width_cnt_q == 4'd0) begin
          burst_cnt_d = burst_inc;
          if (bus.burst_len != 4'd0 && burst_inc == bus.burst_len) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_GAP;
            lfsr_d    = lfsr_next;
            gap_cnt_d = gap_val;
          end
        end else begin
          width_cnt_d = width_cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    pulse_d = (state_d == S_PULSE);
    busy_d  = (state_d == S_GAP) || (state_d == S_PULSE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      gap_cnt_q   <= 9'd0;
      width_cnt_q <= 4'd0;
      burst_cnt_q <= 4'd0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      gap_cnt_q   <= gap_cnt_d;
      width_cnt_q <= width_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pulse = pulse_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef RPS_STATS_EN
  logic [7:0] pcnt_q, pcnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Counted on PULSE entry so an aborted pulse still counts as issued.
  always_comb begin
    pcnt_d = pcnt_q;
    if (state_q == S_IDLE && bus.start) pcnt_d = 8'd0;
    else if (pulse_enter)               pcnt_d = sat_inc8(pcnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= 8'd0;
    else     pcnt_q <= pcnt_d;
  end

  assign bus.pulse_count = pcnt_q;
`else
  logic unused_pulse_enter;
  assign unused_pulse_enter = pulse_enter;
  assign bus.pulse_count    = 8'h00;
`endif

endmodule

// File: tb/tb_random_pulse_scheduler.sv
// Bench for random_pulse_scheduler: directed scenarios plus randomized bursts
// compared cycle by cycle against a timeline model built from burst rules.
module tb_random_pulse_scheduler;
  localparam int MAXN = 1024;
`ifdef RPS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  random_pulse_scheduler_if bus();
  random_pulse_scheduler #(.LFSR_SEED(16'hACE1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  bit e_pulse [0:MAXN-1];
  bit e_busy  [0:MAXN-1];
  bit e_done  [0:MAXN-1];
  int e_cnt   [0:MAXN-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // Index n of the timeline = output value seen between edges k+n-1 and k+n,
  // where edge k is the one that samples start.
  task automatic run_burst(input int bl, input int mg, input int gm, input int pw,
                           input int stop_at, input bit do_seed, input logic [15:0] sv,
                           input bit with_stop, input bit noise);
    int w, t, cnt, g, pst, last, c;
    bit fin;
    for (int n = 0; n < MAXN; n++) begin
      e_pulse[n] = 0; e_busy[n] = 0; e_done[n] = 0; e_cnt[n] = 0;
    end
    if (do_seed) m_lfsr = (sv == 16'h0) ? 16'hACE1 : sv;
    w = (pw == 0) ? 1 : pw;
    t = 0; cnt = 0; fin = 0; last = 0;
    while (!fin) begin
      if ((stop_at > 0 && t >= stop_at) || t > MAXN - 600) begin
        last = t; fin = 1;
      end else begin
        m_lfsr = m_step(m_lfsr);
        g = mg + int'(m_lfsr[7:0] & gm[7:0]);
        for (int n = t + 1; n <= t + g + 1; n++) e_busy[n] = 1;
        pst = t + g + 2;
        for (int n = pst; n < pst + w; n++) begin e_busy[n] = 1; e_pulse[n] = 1; end
        cnt++;
        t = pst + w - 1;
        if (bl != 0 && cnt == bl) begin
          e_done[t + 1] = 1; last = t + 1; fin = 1;
        end
      end
    end
    if (stop_at > 0 && e_busy[stop_at]) begin
      for (int n = stop_at + 1; n < MAXN; n++) begin e_pulse[n] = 0; e_busy[n] = 0; e_done[n] = 0; end
      e_done[stop_at + 1] = 1;
      last = stop_at + 1;
    end
    c = 0;
    for (int n = 1; n < MAXN; n++) begin
      if (e_pulse[n] && !e_pulse[n - 1]) c++;
      e_cnt[n] = STATS ? ((c > 255) ? 255 : c) : 0;
    end

    @(negedge clk);
    bus.burst_len   = bl[3:0];
    bus.min_gap     = mg[7:0];
    bus.gap_mask    = gm[7:0];
    bus.pulse_width = pw[3:0];
    bus.seed_load   = do_seed;
    bus.seed        = sv;
    bus.stop        = with_stop;
    bus.start       = 1'b1;
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0; bus.seed_load = 1'b0;
      check_val($sformatf("pulse[%0d]", n), {31'd0, bus.pulse}, {31'd0, e_pulse[n]});
      check_val($sformatf("busy[%0d]", n),  {31'd0, bus.busy},  {31'd0, e_busy[n]});
      check_val($sformatf("done[%0d]", n),  {31'd0, bus.done},  {31'd0, e_done[n]});
      check_val($sformatf("count[%0d]", n), {24'd0, bus.pulse_count}, e_cnt[n]);
      if (noise && (e_busy[n] || e_done[n]) && $urandom_range(0, 3) == 0) bus.start = 1'b1;
      if (n == stop_at) bus.stop = 1'b1;
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  initial begin
    int bl, mg, gm, pw, sa;
    bit ds, ws;
    logic [15:0] sv;
    bus.start = 0; bus.stop = 0; bus.seed_load = 0; bus.seed = 0;
    bus.burst_len = 0; bus.min_gap = 0; bus.gap_mask = 0; bus.pulse_width = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    check_val("rst_pulse", {31'd0, bus.pulse}, 32'd0);
    check_val("rst_busy",  {31'd0, bus.busy},  32'd0);
    check_val("rst_done",  {31'd0, bus.done},  32'd0);
    check_val("rst_count", {24'd0, bus.pulse_count}, 32'd0);
    check_val("rst_lfsr",  {16'd0, dut.lfsr_q}, 32'h0000ACE1);

    // Default seed, full random mask, single pulse.
    run_burst(1, 0, 8'hFF, 1, 0, 0, 16'h0, 0, 0);
    check_val("lfsr_after_entry", {16'd0, dut.lfsr_q}, 32'h0000E270);

    run_burst(2, 3, 0, 2, 0, 0, 16'h0, 0, 0);
    run_burst(0, 1, 0, 1, 10, 0, 16'h0, 0, 0);

    // Seed load of zero in IDLE restores the default seed.
    @(negedge clk);
    bus.seed_load = 1'b1; bus.seed = 16'h0000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    m_lfsr = 16'hACE1;
    check_val("seed_zero_load", {16'd0, dut.lfsr_q}, 32'h0000ACE1);

    // start+stop together in IDLE, with stray starts while busy.
    run_burst(3, 2, 8'h07, 2, 0, 0, 16'h0, 1, 1);
    // seed_load with start on the same edge.
    run_burst(2, 1, 8'h1F, 1, 0, 1, 16'h1234, 0, 0);

    // Reset in the middle of a pulse.
    @(negedge clk);
    bus.burst_len = 4'd1; bus.min_gap = 8'd3; bus.gap_mask = 8'd0; bus.pulse_width = 4'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mid_pulse_high", {31'd0, bus.pulse}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    check_val("rstp_pulse", {31'd0, bus.pulse}, 32'd0);
    check_val("rstp_busy",  {31'd0, bus.busy},  32'd0);
    check_val("rstp_done",  {31'd0, bus.done},  32'd0);
    check_val("rstp_lfsr",  {16'd0, dut.lfsr_q}, 32'h0000ACE1);
    @(negedge clk);
    check_val("rstp_done2", {31'd0, bus.done}, 32'd0);
    check_val("rstp_busy2", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 25; i++) begin
      bl = $urandom_range(0, 4);
      mg = $urandom_range(0, 15);
      gm = $urandom_range(0, 255) & 8'h1F;
      pw = $urandom_range(0, 5);
      if (bl == 0 || $urandom_range(0, 2) == 0) sa = $urandom_range(1, 60);
      else sa = 0;
      ds = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      ws = $urandom_range(0, 1);
      run_burst(bl, mg, gm, pw, sa, ds, sv, ws, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
